// File: rtl/cnn_acc_pkg.sv
// Shared constants for the 27-lane convolution accumulator: product width
// derivation, accumulator default, saturation bounds and control state encoding.
package cnn_acc_pkg;

  localparam int ACC_W_DEFAULT = 32;
  localparam int TREE_LANES    = 27;
  localparam int TREE_STAGES   = 5;
  localparam int TREE_GROWTH   = 5;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;

  function automatic int pw_of(int bits, int frac);
    return 2 * bits - frac;
  endfunction

  function automatic longint sat_hi(int bits);
    return (longint'(1) << (bits - 1)) - 1;
  endfunction

  function automatic longint sat_lo(int bits);
    return -(longint'(1) << (bits - 1));
  endfunction

endpackage

// File: rtl/adder_tree_27.sv
// Registered 27->14->7->4->2->1 adder tree with a matching valid pipe.
// Lanes are sign-extended once at the input so every level adds exactly.
module adder_tree_27
  import cnn_acc_pkg::*;
#(
  parameter int PW = 21,
  localparam int SW = PW + TREE_GROWTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PW*TREE_LANES-1:0]  products,
  input  logic                      valid_in,
  output logic [SW-1:0]             sum,
  output logic                      sum_valid
);

  logic [TREE_LANES-1:0][SW-1:0] lvl0;
  logic [13:0][SW-1:0]           lvl1;
  logic [6:0][SW-1:0]            lvl2;
  logic [3:0][SW-1:0]            lvl3;
  logic [1:0][SW-1:0]            lvl4;
  logic [SW-1:0]                 lvl5;
  logic [TREE_STAGES-1:0]        vld_pipe;

  always_comb begin
    lvl0 = '0;
    for (int i = 0; i < TREE_LANES; i++) begin
      lvl0[i] = {{TREE_GROWTH{products[i*PW+PW-1]}}, products[i*PW +: PW]};
    end
  end

  // Odd-sized levels pass their last operand straight through to the next level.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 13; i++) lvl1[i] <= lvl0[2*i] + lvl0[2*i+1];
    lvl1[13] <= lvl0[26];
    for (int i = 0; i < 7; i++) lvl2[i] <= lvl1[2*i] + lvl1[2*i+1];
    for (int i = 0; i < 3; i++) lvl3[i] <= lvl2[2*i] + lvl2[2*i+1];
    lvl3[3] <= lvl2[6];
    for (int i = 0; i < 2; i++) lvl4[i] <= lvl3[2*i] + lvl3[2*i+1];
    lvl5 <= lvl4[0] + lvl4[1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[TREE_STAGES-2:0], valid_in};
    end
  end

  assign sum       = lvl5;
  assign sum_valid = vld_pipe[TREE_STAGES-1];

endmodule

// File: rtl/conv_accumulator_27.sv
// Accumulates num_groups tree sums plus a bias and emits a saturated result.
// Optional macro CONV_ACC_RELU_EN clamps negative results to zero.
module conv_accumulator_27
  import cnn_acc_pkg::*;
#(
  parameter int bitsize   = 14,
  parameter int FRAC_BITS = 7,
  parameter int ACC_W     = ACC_W_DEFAULT,
  localparam int PW = pw_of(bitsize, FRAC_BITS),
  localparam int SW = PW + TREE_GROWTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PW*TREE_LANES-1:0] products,
  input  logic                     valid_in,
  input  logic [bitsize-1:0]       bias,
  input  logic [7:0]               num_groups,
  output logic [bitsize-1:0]       result,
  output logic                     out_valid,
  output logic                     sat
);

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(sat_hi(bitsize));
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(sat_lo(bitsize));
  localparam logic [bitsize-1:0]      RES_MAX = bitsize'(sat_hi(bitsize));
  localparam logic [bitsize-1:0]      RES_MIN = bitsize'(sat_lo(bitsize));

  logic [SW-1:0]                          tree_sum;
  logic                                   tree_valid;
  logic [TREE_STAGES-1:0][bitsize-1:0]    bias_pipe;
  logic [TREE_STAGES-1:0][7:0]            ngrp_pipe;
  logic [0:0]                             state;
  logic [7:0]                             count;
  logic [7:0]                             target;
  logic signed [ACC_W-1:0]                acc;
  logic                                   acc_done;
  logic signed [ACC_W-1:0]                tree_ext;
  logic signed [ACC_W-1:0]                bias_ext;
  logic [7:0]                             first_target;
  logic [7:0]                             next_count;
  logic [bitsize-1:0]                     clip_val;
  logic                                   clip_sat;

  adder_tree_27 #(.PW(PW)) u_tree (
    .clk       (clk),
    .rst       (rst),
    .products  (products),
    .valid_in  (valid_in),
    .sum       (tree_sum),
    .sum_valid (tree_valid)
  );

  // Bias and group count ride alongside each group so the first group of a sum
  // carries the values that were present when it entered the tree.
  always_ff @(posedge clk) begin
    bias_pipe <= {bias_pipe[TREE_STAGES-2:0], bias};
    ngrp_pipe <= {ngrp_pipe[TREE_STAGES-2:0], num_groups};
  end

  always_comb begin
    tree_ext     = {{(ACC_W-SW){tree_sum[SW-1]}}, tree_sum};
    bias_ext     = {{(ACC_W-bitsize){bias_pipe[TREE_STAGES-1][bitsize-1]}},
                    bias_pipe[TREE_STAGES-1]};
    first_target = (ngrp_pipe[TREE_STAGES-1] == 8'd0) ? 8'd1 : ngrp_pipe[TREE_STAGES-1];
    next_count   = count + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      count    <= '0;
      target   <= '0;
      acc      <= '0;
      acc_done <= 1'b0;
    end else begin
      acc_done <= 1'b0;
      if (tree_valid) begin
        if (state == ST_IDLE) begin
          acc    <= bias_ext + tree_ext;
          target <= first_target;
          if (first_target == 8'd1) begin
            acc_done <= 1'b1;
            count    <= '0;
          end else begin
            state <= ST_ACCUM;
            count <= 8'd1;
          end
        end else begin
          acc <= acc + tree_ext;
          if (next_count == target) begin
            acc_done <= 1'b1;
            count    <= '0;
            state    <= ST_IDLE;
          end else begin
            count <= next_count;
          end
        end
      end
    end
  end

  always_comb begin
    clip_val = acc[bitsize-1:0];
    clip_sat = 1'b0;
    if (acc > SAT_MAX) begin
      clip_val = RES_MAX;
      clip_sat = 1'b1;
    end else if (acc < SAT_MIN) begin
      clip_val = RES_MIN;
      clip_sat = 1'b1;
    end
`ifdef CONV_ACC_RELU_EN
    if (clip_val[bitsize-1]) begin
      clip_val = '0;
      clip_sat = 1'b0;
    end
`else
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result    <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= acc_done;
      if (acc_done) begin
        result <= clip_val;
        sat    <= clip_sat;
      end
    end
  end

endmodule

// File: tb/tb_conv_accumulator_27.sv
// Scoreboard bench for conv_accumulator_27: a group-level reference model
// predicts each completed sum; a negedge monitor checks value, sat and timing.
module tb_conv_accumulator_27;

  localparam int PW    = 21;
  localparam int LANES = 27;
  localparam int OUT_LATENCY = 7;
  localparam longint RES_MAX = 8191;
  localparam longint RES_MIN = -8192;

  typedef struct {
    logic signed [13:0] res;
    logic               sat;
    int                 cyc;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [PW*LANES-1:0]   products;
  logic                  valid_in;
  logic [13:0]           bias;
  logic [7:0]            num_groups;
  logic [13:0]           result;
  logic                  out_valid;
  logic                  sat;

  exp_t                  sb[$];
  logic signed [PW-1:0]  lane_val [LANES];
  int                    checks = 0;
  int                    errors = 0;
  int                    cyc = 0;
  bit                    armed = 1'b0;
  logic signed [13:0]    hold_res = '0;
  logic                  hold_sat = 1'b0;
  int                    remaining = 0;
  longint                accum = 0;

  conv_accumulator_27 dut (
    .clk        (clk),
    .rst        (rst),
    .products   (products),
    .valid_in   (valid_in),
    .bias       (bias),
    .num_groups (num_groups),
    .result     (result),
    .out_valid  (out_valid),
    .sat        (sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog");
  end

  function automatic exp_t model_out(longint v, int c);
    exp_t e;
    e.cyc = c;
    e.sat = 1'b0;
    if (v > RES_MAX) begin
      e.res = 14'(RES_MAX);
      e.sat = 1'b1;
    end else if (v < RES_MIN) begin
      e.res = 14'(RES_MIN);
      e.sat = 1'b1;
    end else begin
      e.res = 14'(v);
    end
`ifdef CONV_ACC_RELU_EN
    if (e.res < 0) begin
      e.res = '0;
      e.sat = 1'b0;
    end
`endif
    return e;
  endfunction

  task automatic checkValue(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkValue("result", longint'($signed(result)), longint'(e.res));
    checkValue("sat", longint'(sat), longint'(e.sat));
    checkValue("latency_cycle", longint'(cyc), longint'(e.cyc));
  endtask

  always @(negedge clk) begin
    if (armed && !rst) begin
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_out_valid: got pulse at cycle %0d required none", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput(e);
          hold_res = e.res;
          hold_sat = e.sat;
        end
      end else begin
        checks++;
        if (out_valid !== 1'b0 || result !== hold_res || sat !== hold_sat) begin
          errors++;
          $display("[TB] FAIL hold: got valid=%b result=%0d sat=%b required valid=0 result=%0d sat=%b",
                   out_valid, $signed(result), sat, hold_res, hold_sat);
        end
      end
    end
  end

  task automatic randomizeIdleInputs();
    for (int i = 0; i < LANES; i++) products[i*PW +: PW] = PW'($urandom);
    bias       = 14'($urandom);
    num_groups = 8'($urandom);
  endtask

  task automatic fillLanes(input int mode);
    for (int i = 0; i < LANES; i++) begin
      case (mode)
        0:       lane_val[i] = PW'(int'($urandom_range(0, 80)) - 40);
        1:       lane_val[i] = PW'(int'($urandom_range(0, 1200)) - 600);
        default: lane_val[i] = PW'($urandom);
      endcase
    end
  endtask

  task automatic fillConst(input int v);
    for (int i = 0; i < LANES; i++) lane_val[i] = PW'(v);
  endtask

  // Presents one group for a single cycle; ng and b only matter on a sum's first group.
  task automatic applyStimulus(input int ng, input int b);
    longint gsum;
    gsum = 0;
    for (int i = 0; i < LANES; i++) begin
      products[i*PW +: PW] = lane_val[i];
      gsum += longint'(lane_val[i]);
    end
    valid_in   = 1'b1;
    bias       = 14'(b);
    num_groups = 8'(ng);
    if (remaining == 0) begin
      accum     = longint'(b) + gsum;
      remaining = (ng == 0) ? 1 : ng;
    end else begin
      accum += gsum;
    end
    remaining--;
    if (remaining == 0) sb.push_back(model_out(accum, cyc + OUT_LATENCY));
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    randomizeIdleInputs();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d outputs pending required 0", sb.size());
      sb.delete();
    end
    idle(3);
  endtask

  task automatic doReset();
    rst       = 1'b1;
    remaining = 0;
    sb.delete();
    hold_res  = '0;
    hold_sat  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int ng, b, gap;
    rst        = 1'b1;
    valid_in   = 1'b0;
    bias       = '0;
    num_groups = '0;
    products   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst   = 1'b0;
    armed = 1'b1;
    @(negedge clk);
    checkValue("reset_out_valid", longint'(out_valid), 0);
    checkValue("reset_result", longint'($signed(result)), 0);
    checkValue("reset_sat", longint'(sat), 0);
    @(posedge clk);
    #1;

    $display("[TB] single group, unit products");
    fillConst(128);
    applyStimulus(1, 0);
    drain();

    $display("[TB] three groups with bias");
    fillConst(1);
    applyStimulus(3, 64);
    applyStimulus(9, 500);
    applyStimulus(0, -300);
    drain();

    $display("[TB] positive and negative saturation");
    fillConst(8191);
    applyStimulus(4, 0);
    repeat (3) applyStimulus(1, 777);
    drain();
    fillConst(-8192);
    applyStimulus(4, 0);
    repeat (3) applyStimulus(2, -777);
    drain();

    $display("[TB] back-to-back sums with internal bubble");
    fillLanes(0);
    applyStimulus(2, 100);
    idle(2);
    fillLanes(0);
    applyStimulus(5, 3000);
    fillLanes(0);
    applyStimulus(2, -50);
    fillLanes(0);
    applyStimulus(1, 4000);
    drain();

    $display("[TB] reset mid-sum");
    fillLanes(1);
    applyStimulus(4, 200);
    fillLanes(1);
    applyStimulus(4, 200);
    doReset();
    fillLanes(0);
    applyStimulus(1, -123);
    drain();
    idle(10);

    $display("[TB] zero group count and mid-sum count change");
    fillLanes(0);
    applyStimulus(0, 5);
    fillLanes(0);
    applyStimulus(3, -20);
    fillLanes(0);
    applyStimulus(1, 30);
    fillLanes(0);
    applyStimulus(7, 1000);
    drain();

    $display("[TB] randomized sums");
    for (int s = 0; s < 25; s++) begin
      ng = int'($urandom_range(0, 5));
      b  = int'($urandom_range(0, 16383)) - 8192;
      for (int g = 0; g < ((ng == 0) ? 1 : ng); g++) begin
        fillLanes(int'($urandom_range(0, 2)));
        applyStimulus((g == 0) ? ng : int'($urandom_range(0, 255)),
                      (g == 0) ? b : int'($urandom_range(0, 16383)) - 8192);
        gap = int'($urandom_range(0, 3));
        if (gap > 1) idle(gap - 1);
      end
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_accumulator_27.md
CONV_ACCUMULATOR_27 -- requirements
Module: conv_accumulator_27

Interface
REQ-001 Parameter bitsize, 14: width of signed operands and of the final result.
REQ-002 Parameter FRAC_BITS, 7: fractional bits of products, bias and result.
REQ-003 Parameter ACC_W, 32: signed accumulator width.
REQ-004 Derived PW = 2*bitsize-FRAC_BITS (21): width of each incoming product lane.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 products  input  PW*27  27 signed products, lane i at bits [i*PW+PW-1 : i*PW], from the upstream 27-lane multiplier.
REQ-008 valid_in  input  1  products valid this cycle (upstream valid); one group per high cycle.
REQ-009 bias  input  bitsize  signed bias, same fraction as products; sampled with the first group of a sum.
REQ-010 num_groups  input  8  groups (27-product sets) per output; sampled with the first group of a sum.
REQ-011 result  output  bitsize  saturated signed output.
REQ-012 out_valid  output  1  result valid, one-cycle pulse per completed sum.
REQ-013 sat  output  1  result was clipped; qualified by out_valid.

Function
REQ-014 Fully pipelined, no backpressure; valid_in may be high every cycle.
REQ-015 Adder tree: 27->14->7->4->2->1, each level registered (5 stages), sign-extended to PW+5 bits, exact (no truncation).
REQ-016 Valid shift register tracks the tree; bubbles (valid_in low) do not disturb sums in flight.
REQ-017 Two-state control: IDLE (group count 0) and ACCUM; first tree-valid in IDLE loads acc = sign-extended bias + tree_sum, latches num_groups, goes ACCUM (or completes immediately if latched count is 1).
REQ-018 In ACCUM each tree-valid adds tree_sum to acc and increments count; on count reaching latched num_groups the sum completes, state returns to IDLE, count returns to 0.
REQ-019 num_groups = 0 SHALL be treated as 1.
REQ-020 Changes to num_groups or bias mid-sum SHALL have no effect until the next sum.
REQ-021 Back-to-back: a tree-valid in the cycle after completion SHALL start a new sum (bias reload) with no lost group and no idle cycle.
REQ-022 Output register: result = acc clipped to [-2^(bitsize-1), 2^(bitsize-1)-1], sat = 1 iff clipped; out_valid high exactly one cycle.
REQ-023 Latency: out_valid SHALL be high 7 cycles after the edge sampling the final group's valid_in (5 tree + 1 acc + 1 output).
REQ-024 result and sat hold their last values while out_valid is low.

Reset
REQ-025 On rst: result=0, out_valid=0, sat=0, acc=0, count=0, state IDLE, all tree valid bits 0.
REQ-026 Reset mid-sum discards partial sum and in-flight groups; first valid_in after rst deasserts starts a new sum.

Configuration
REQ-027 Macro CONV_ACC_RELU_EN defined: negative saturated results output as 0 with sat=0; undefined: signed result passed unchanged.

Structure
REQ-028 Package cnn_acc_pkg holds PW derivation, ACC_W default, saturation bounds and state encoding constants.
REQ-029 Sub-module adder_tree_27 (registered 5-level tree with valid pipe); control, accumulator and saturation stay in the top.

Verification
REQ-030 num_groups=1, bias=0, all 27 products=+128 (1.0) -> out_valid at +7 cycles, result=3456, sat=0.
REQ-031 num_groups=3, bias=64, groups of all +1, valid_in 3 consecutive cycles -> single out_valid, result=64+81=145.
REQ-032 Products all +8191 over 4 groups -> result=8191, sat=1; all -8192 -> result=-8192, sat=1 (ReLU build: 0, sat=0).
REQ-033 Two num_groups=2 sums back-to-back with 2-cycle bubble inside first -> two pulses, correct independent sums, second not contaminated by bias of first.
REQ-034 rst asserted after 2 of 4 groups, then a num_groups=1 sum -> no out_valid for aborted sum; new result correct.
REQ-035 num_groups=0 and num_groups changed mid-sum -> behaves as 1 and as latched value respectively.
